regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file. It is the next-generation replacement for the CPU's single-write 32x32 register file.
- Adds:
  - configurable width and depth
  - a second write port with fixed priority
  - per-byte write enables
  - optional write-to-read bypass
  - a per-register pending-write scoreboard, so multi-cycle load/ALU ops can flag hazards
- Sits between the decode and writeback stages of the datapath. It also keeps the debug test read port used by the display/test logic.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wmerge.sv | 25 ++
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int ZERO_IDX     = 0;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/regfile_wmerge.sv
// Byte-wise merge of a register's old value with both write ports; port 1 wins per byte.
module regfile_wmerge
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic                hit0_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  input  logic [DATA_W/8-1:0] wbe0_i,
  input  logic                hit1_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  input  logic [DATA_W/8-1:0] wbe1_i,
  output logic [DATA_W-1:0]   merged_o
);
  localparam int NB = lanes(DATA_W);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < NB; b++) begin
      if (hit1_i && wbe1_i[b])      merged_o[b*8 +: 8] = wdata1_i[b*8 +: 8];
      else if (hit0_i && wbe0_i[b]) merged_o[b*8 +: 8] = wdata0_i[b*8 +: 8];
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with byte enables, optional bypass,
// pending-write scoreboard and an unbypassed debug read port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rd_a_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  output logic                rd_a_busy,
  input  logic [ADDR_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]   rd_b_data,
  output logic                rd_b_busy,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   waddr0,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W/8-1:0] wbe0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   waddr1,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] wbe1,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_addr,
  input  logic [ADDR_W-1:0]   test_idx,
  output logic [DATA_W-1:0]   test_data
);
  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic                            wr0_ok, wr1_ok, sb_ok;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (int'(a) == ZERO_IDX));
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (int'(a) == r) v = mem_q[r];
    return v;
  endfunction

  function automatic logic busy_rd(input logic [ADDR_W-1:0] a);
    logic v;
    v = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      if (int'(a) == r) v = busy_q[r];
    return v;
  endfunction

  // An effective write needs a writable address and at least one byte lane.
  assign wr0_ok = we0 && addr_ok(waddr0) && (|wbe0);
  assign wr1_ok = we1 && addr_ok(waddr1) && (|wbe1);
  assign sb_ok  = sb_set && addr_ok(sb_addr);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic hit0, hit1;
    assign hit0 = wr0_ok && (int'(waddr0) == r);
    assign hit1 = wr1_ok && (int'(waddr1) == r);

    regfile_wmerge #(.DATA_W(DATA_W)) u_wm (
      .old_i(mem_q[r]), .hit0_i(hit0), .wdata0_i(wdata0), .wbe0_i(wbe0),
      .hit1_i(hit1), .wdata1_i(wdata1), .wbe1_i(wbe1), .merged_o(mem_d[r])
    );

    // A new producer issued in the same cycle as a write keeps the bit set.
    assign busy_d[r] = (sb_ok && (int'(sb_addr) == r)) | (busy_q[r] & ~(hit0 | hit1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  logic              ok_a, ok_b, byp_a0, byp_a1, byp_b0, byp_b1;
  logic [DATA_W-1:0] mrg_a, mrg_b;

  assign ok_a   = addr_ok(rd_a_addr);
  assign ok_b   = addr_ok(rd_b_addr);
  assign byp_a0 = (BYPASS != 0) && wr0_ok && (waddr0 == rd_a_addr);
  assign byp_a1 = (BYPASS != 0) && wr1_ok && (waddr1 == rd_a_addr);
  assign byp_b0 = (BYPASS != 0) && wr0_ok && (waddr0 == rd_b_addr);
  assign byp_b1 = (BYPASS != 0) && wr1_ok && (waddr1 == rd_b_addr);

  regfile_wmerge #(.DATA_W(DATA_W)) u_byp_a (
    .old_i(mem_rd(rd_a_addr)), .hit0_i(byp_a0), .wdata0_i(wdata0), .wbe0_i(wbe0),
    .hit1_i(byp_a1), .wdata1_i(wdata1), .wbe1_i(wbe1), .merged_o(mrg_a)
  );

  regfile_wmerge #(.DATA_W(DATA_W)) u_byp_b (
    .old_i(mem_rd(rd_b_addr)), .hit0_i(byp_b0), .wdata0_i(wdata0), .wbe0_i(wbe0),
    .hit1_i(byp_b1), .wdata1_i(wdata1), .wbe1_i(wbe1), .merged_o(mrg_b)
  );

  assign rd_a_data = ok_a ? mrg_a : '0;
  assign rd_b_data = ok_b ? mrg_b : '0;
  assign rd_a_busy = ok_a && busy_rd(rd_a_addr);
  assign rd_b_busy = ok_b && busy_rd(rd_b_addr);
  assign test_data = addr_ok(test_idx) ? mem_rd(test_idx) : '0;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing 32-entry instance and a non-bypassing 24-entry instance share stimulus.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_a_addr, rd_b_addr, waddr0, waddr1, sb_addr, test_idx;
  logic        we0, we1, sb_set;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  wbe0, wbe1;

  logic [31:0] a_data, b_data, t_data, na_data, nb_data, nt_data;
  logic        a_busy, b_busy, na_busy, nb_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst),
    .rd_a_addr(rd_a_addr), .rd_a_data(a_data), .rd_a_busy(a_busy),
    .rd_b_addr(rd_b_addr), .rd_b_data(b_data), .rd_b_busy(b_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wbe0(wbe0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wbe1(wbe1),
    .sb_set(sb_set), .sb_addr(sb_addr), .test_idx(test_idx), .test_data(t_data)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .BYPASS(0), .ZERO_REG(1)) u_nbyp (
    .clk(clk), .rst(rst),
    .rd_a_addr(rd_a_addr), .rd_a_data(na_data), .rd_a_busy(na_busy),
    .rd_b_addr(rd_b_addr), .rd_b_data(nb_data), .rd_b_busy(nb_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wbe0(wbe0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wbe1(wbe1),
    .sb_set(sb_set), .sb_addr(sb_addr), .test_idx(test_idx), .test_data(nt_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0; wbe0 = 4'h0; wbe1 = 4'h0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we0 = 1'b1; waddr0 = a; wdata0 = d; wbe0 = be;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we1 = 1'b1; waddr1 = a; wdata1 = d; wbe1 = be;
  endtask

  task automatic sb(input logic [4:0] a);
    sb_set = 1'b1; sb_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    rd_a_addr = '0; rd_b_addr = '0; waddr0 = '0; waddr1 = '0; sb_addr = '0; test_idx = '0;
    wdata0 = '0; wdata1 = '0;
    idle();
    tick();
    rst = 1'b0;

    // reset clears a written register and all busy bits
    wr0(5'd5, 32'hDEADBEEF, 4'hF); sb(5'd5);
    tick(); idle();
    rd_a_addr = 5'd5; #1;
    chk("r5_written", a_data, 32'hDEADBEEF);
    chk("r5_busy_set", {31'd0, a_busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("r5_after_rst", a_data, 32'h0);
    chk("r5_busy_after_rst", {31'd0, a_busy}, 32'd0);
    chk("nbyp_r5_after_rst", na_data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      test_idx = 5'(i); rd_b_addr = 5'(i); #1;
      chk($sformatf("test_rst_%0d", i), t_data, 32'h0);
      chk($sformatf("busy_rst_%0d", i), {31'd0, b_busy}, 32'd0);
    end

    // r0 is hardwired to zero and never busy
    rd_a_addr = 5'd0;
    wr0(5'd0, 32'hFFFFFFFF, 4'hF); #1;
    chk("r0_bypass", a_data, 32'h0);
    tick(); idle(); sb(5'd0);
    tick(); idle(); #1;
    chk("r0_data", a_data, 32'h0);
    chk("r0_busy", {31'd0, a_busy}, 32'd0);
    test_idx = 5'd0; #1;
    chk("r0_test", t_data, 32'h0);

    // dual-write collision on r7
    wr0(5'd7, 32'h11223344, 4'hF);
    tick(); idle();
    rd_b_addr = 5'd7;
    wr0(5'd7, 32'hAAAAAAAA, 4'hF); wr1(5'd7, 32'h55555555, 4'h3); #1;
    chk("r7_bypass", b_data, 32'hAAAA5555);
    chk("r7_nobypass", nb_data, 32'h11223344);
    tick(); idle(); #1;
    chk("r7_stored", b_data, 32'hAAAA5555);
    chk("r7_stored_nbyp", nb_data, 32'hAAAA5555);

    // byte enables on r9
    rd_a_addr = 5'd9;
    wr0(5'd9, 32'h12345678, 4'h4);
    tick(); idle(); #1;
    chk("r9_lane2", a_data, 32'h00340000);
    sb(5'd9);
    tick(); idle();
    wr0(5'd9, 32'hFFFFFFFF, 4'h0); #1;
    chk("r9_zero_be_bypass", a_data, 32'h00340000);
    tick(); idle(); #1;
    chk("r9_zero_be_data", a_data, 32'h00340000);
    chk("r9_zero_be_busy", {31'd0, a_busy}, 32'd1);

    // scoreboard on r3
    rd_a_addr = 5'd3;
    sb(5'd3); #1;
    chk("r3_busy_c1", {31'd0, a_busy}, 32'd0);
    tick(); idle(); #1;
    chk("r3_busy_c2", {31'd0, a_busy}, 32'd1);
    tick(); tick();
    wr0(5'd3, 32'h33333333, 4'hF); sb(5'd3);
    tick(); idle(); #1;
    chk("r3_busy_c5", {31'd0, a_busy}, 32'd1);
    chk("r3_data_c5", a_data, 32'h33333333);
    tick();
    wr1(5'd3, 32'hCAFEF00D, 4'hF); #1;
    chk("r3_busy_not_bypassed", {31'd0, a_busy}, 32'd1);
    tick(); idle(); #1;
    chk("r3_busy_c7", {31'd0, a_busy}, 32'd0);
    chk("r3_data_c7", a_data, 32'hCAFEF00D);

    // reset beats a same-cycle write and sb_set
    rd_a_addr = 5'd12;
    wr0(5'd12, 32'h12121212, 4'hF);
    tick(); idle(); sb(5'd12);
    tick(); idle(); #1;
    chk("r12_pre_busy", {31'd0, a_busy}, 32'd1);
    rst = 1'b1; wr1(5'd12, 32'h99999999, 4'hF); sb(5'd12);
    tick(); rst = 1'b0; idle(); #1;
    chk("r12_rst_data", a_data, 32'h0);
    chk("r12_rst_busy", {31'd0, a_busy}, 32'd0);

    // rst pulse between edges leaves state alone
    rd_a_addr = 5'd20;
    wr0(5'd20, 32'h20202020, 4'hF);
    tick(); idle();
    rst = 1'b1; #2;
    chk("r20_rst_between", a_data, 32'h20202020);
    rst = 1'b0;
    tick(); #1;
    chk("r20_after_edge", a_data, 32'h20202020);

    // out-of-range address on the 24-entry instance
    rd_a_addr = 5'd28; test_idx = 5'd28;
    wr0(5'd28, 32'h28282828, 4'hF); sb(5'd28);
    tick(); idle(); #1;
    chk("oor_data", na_data, 32'h0);
    chk("oor_busy", {31'd0, na_busy}, 32'd0);
    chk("oor_test", nt_data, 32'h0);
    chk("inrange_big", a_data, 32'h28282828);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
